// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - opcodes, control encodings and state enum shared by the RV32I sequencer
package rv_ctrl_pkg;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] BTYPE = 7'b1100011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, HALT} state_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_NONE = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_ALU = 2'd2} pc_src_e;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_LOAD = 2'd1, WB_PC4 = 2'd2} wb_sel_e;
    typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_BRANCH = 2'd1, ALU_FUNCT = 2'd2} alu_op_e;

    typedef enum logic [2:0] {
        CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_OP, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_ILLEGAL
    } op_class_e;

    function automatic op_class_e classify(input logic [6:0] opcode);
        case (opcode)
            LOAD:    return CLS_LOAD;
            STORE:   return CLS_STORE;
            OPIMM:   return CLS_OPIMM;
            OP:      return CLS_OP;
            BTYPE:   return CLS_BRANCH;
            JAL:     return CLS_JAL;
            JALR:    return CLS_JALR;
            default: return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic imm_sel_e imm_of(input op_class_e cls);
        case (cls)
            CLS_LOAD, CLS_OPIMM, CLS_JALR: return IMM_I;
            CLS_STORE:                     return IMM_S;
            CLS_BRANCH:                    return IMM_B;
            CLS_JAL:                       return IMM_J;
            default:                       return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts consecutive memory stall cycles and flags the timeout cycle
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_en,
    output logic expired
);

    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] wait_cnt;

    // A stall run is contiguous until mem_ready, so any non-stall cycle restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n || !wait_en) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign expired = wait_en && (wait_cnt == LAST_WAIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - RV32I multi-cycle control sequencer; CTRL_PERF_CNT_EN adds perf counters
module multicycle_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_data,
    output logic             ir_write,
    output logic [2:0]       imm_sel,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             instr_done,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_e    state;
    op_class_e cls;
    logic      mem_wait;
    logic      mem_done;
    logic      timeout;
    logic      unused_instr_bits;

    assign mem_wait          = mem_req && !mem_ready;
    assign mem_done          = mem_req && mem_ready;
    assign unused_instr_bits = ^instr[31:7];

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wait_en (mem_wait),
        .expired (timeout)
    );

    // The request lines are registered so they stay put for the whole handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            cls         <= CLS_ILLEGAL;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_is_data <= 1'b0;
            illegal     <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            case (state)
                FETCH, MEM: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ready) begin
                        mem_we      <= 1'b0;
                        mem_is_data <= 1'b0;
                        if (state == MEM && cls == CLS_STORE) begin
                            state <= FETCH;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= (state == FETCH) ? DECODE : WB;
                        end
                    end else if (timeout) begin
                        mem_req <= 1'b0;
                        mem_err <= 1'b1;
                        state   <= HALT;
                    end
                end
                DECODE: begin
                    cls <= classify(instr[6:0]);
                    case (classify(instr[6:0]))
                        CLS_BRANCH:        state <= BRANCH;
                        CLS_JAL, CLS_JALR: state <= JUMP;
                        CLS_ILLEGAL: begin
                            illegal <= 1'b1;
                            state   <= HALT;
                        end
                        default:           state <= EXEC;
                    endcase
                end
                EXEC: begin
                    if (cls == CLS_LOAD || cls == CLS_STORE) begin
                        mem_req     <= 1'b1;
                        mem_is_data <= 1'b1;
                        mem_we      <= (cls == CLS_STORE);
                        state       <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                WB, BRANCH, JUMP: begin
                    mem_req <= 1'b1;
                    state   <= FETCH;
                end
                default: state <= HALT;
            endcase
        end
    end

    always_comb begin
        ir_write   = 1'b0;
        imm_sel    = IMM_NONE;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        wb_sel     = WB_ALU;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        instr_done = 1'b0;
        case (state)
            FETCH: begin
                ir_write = mem_done;
                pc_write = mem_done;
            end
            DECODE: imm_sel = imm_of(classify(instr[6:0]));
            EXEC: begin
                imm_sel   = imm_of(cls);
                alu_src_b = (cls != CLS_OP);
                alu_op    = (cls == CLS_LOAD || cls == CLS_STORE) ? ALU_ADD : ALU_FUNCT;
            end
            MEM: begin
                imm_sel    = imm_of(cls);
                instr_done = mem_done && (cls == CLS_STORE);
            end
            WB: begin
                imm_sel    = imm_of(cls);
                reg_write  = 1'b1;
                wb_sel     = (cls == CLS_LOAD) ? WB_LOAD : WB_ALU;
                instr_done = 1'b1;
            end
            BRANCH: begin
                imm_sel    = IMM_B;
                alu_op     = ALU_BRANCH;
                pc_src     = PC_IMM;
                pc_write   = branch_taken;
                instr_done = 1'b1;
            end
            JUMP: begin
                imm_sel    = imm_of(cls);
                reg_write  = 1'b1;
                wb_sel     = WB_PC4;
                pc_write   = 1'b1;
                pc_src     = (cls == CLS_JAL) ? PC_IMM : PC_ALU;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else if (state != HALT) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (instr_done) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
